// File: rtl/bp_fe_icache_mem_responder.sv
// bp_fe_icache_mem_responder
//
// Memory-side responder for the front-end I$ fill path. Accepts one
// bedrock-style memory command at a time (block read, block write, uncached
// read, uncached write) and services it from an internal block array. It
// returns exactly one response per command after a programmable latency.
//
// Array writes take effect at the end of the accept cycle, so any later
// read sees the new data. The write response still waits out the latency.
// Reset does not clear the array. It discards any command in flight along
// with its pending response.
//
// Optional feature macro: BP_FE_MEM_RESP_LFSR_LATENCY_EN
//   When defined, each command waits latency_p + lfsr[3:0] extra cycles.
//   The LFSR is an 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'h01, and
//   steps once per accepted command.
//   When undefined, the extra latency is exactly latency_p and no LFSR
//   is built.
//
// Ports
//   clk_i               clock
//   reset_i             asynchronous active-high reset
//   mem_cmd_v_i         command valid
//   mem_cmd_ready_o     command ready (valid/ready handshake)
//   mem_cmd_opcode_i    0=rd block, 1=wr block, 2=uc_rd, 3=uc_wr
//   mem_cmd_addr_i      byte address
//   mem_cmd_size_i      log2 bytes (uncached ops only)
//   mem_cmd_payload_i   opaque payload, echoed on the response
//   mem_cmd_data_i      write data (uncached data right-aligned)
//   mem_resp_v_o        response valid
//   mem_resp_yumi_i     response consumed
//   mem_resp_opcode_o   echoed opcode
//   mem_resp_addr_o     echoed address
//   mem_resp_size_o     echoed size
//   mem_resp_payload_o  echoed payload
//   mem_resp_data_o     read data, zero for writes
//
// State table
//   state  | meaning
//   S_IDLE | ready for a command; latch it and load the latency counter
//   S_WAIT | counting down the latency, no command accepted
//   S_RESP | response valid and held stable until yumi

module bp_fe_icache_mem_responder
#(
    parameter int                       paddr_width_p   = 40,
    parameter int                       block_width_p   = 512,
    parameter int                       mem_els_p       = 1024,
    parameter logic [paddr_width_p-1:0] mem_offset_p    = 40'h8000_0000,
    parameter int                       latency_p       = 4,
    parameter int                       payload_width_p = 16
)
(
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       mem_cmd_v_i,
    output logic                       mem_cmd_ready_o,
    input  logic [1:0]                 mem_cmd_opcode_i,
    input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
    input  logic [2:0]                 mem_cmd_size_i,
    input  logic [payload_width_p-1:0] mem_cmd_payload_i,
    input  logic [block_width_p-1:0]   mem_cmd_data_i,

    output logic                       mem_resp_v_o,
    input  logic                       mem_resp_yumi_i,
    output logic [1:0]                 mem_resp_opcode_o,
    output logic [paddr_width_p-1:0]   mem_resp_addr_o,
    output logic [2:0]                 mem_resp_size_o,
    output logic [payload_width_p-1:0] mem_resp_payload_o,
    output logic [block_width_p-1:0]   mem_resp_data_o
);

    localparam int block_bytes_lp = block_width_p / 8;
    localparam int offset_bits_lp = $clog2(block_bytes_lp);
    localparam int idx_bits_lp    = $clog2(mem_els_p);
    localparam int words_lp       = block_width_p / 64;
    // Wide enough for 255 + 15 when the LFSR jitter is enabled.
    localparam int cnt_width_lp   = 9;

    localparam logic [cnt_width_lp-1:0] latency_lp = cnt_width_lp'(latency_p);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp = cnt_width_lp'(1);

    localparam logic [1:0] op_rd_lp    = 2'd0;
    localparam logic [1:0] op_wr_lp    = 2'd1;
    localparam logic [1:0] op_uc_rd_lp = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
    logic [cnt_width_lp-1:0]    lat_total;
    logic                       cmd_accept;

    logic [1:0]                 resp_opcode_q;
    logic [paddr_width_p-1:0]   resp_addr_q;
    logic [2:0]                 resp_size_q;
    logic [payload_width_p-1:0] resp_payload_q;
    logic [block_width_p-1:0]   resp_data_q, resp_data_d;

    logic [block_width_p-1:0]   mem_q [mem_els_p];

    logic [paddr_width_p-1:0]   rel_addr;
    logic [idx_bits_lp-1:0]     cmd_idx;
    logic [offset_bits_lp-1:0]  byte_off;
    logic [offset_bits_lp-1:0]  off_aligned;
    logic [offset_bits_lp+2:0]  bit_shamt;
    logic [1:0]                 uc_size;
    logic [block_width_p-1:0]   rd_block;
    logic [63:0]                uc_src_word;
    logic [63:0]                uc_word;
    logic [block_width_p-1:0]   uc_rdata;
    logic [63:0]                lane_mask;
    logic [block_width_p-1:0]   wr_mask_ext;
    logic [block_width_p-1:0]   wr_data_ext;
    logic [block_width_p-1:0]   uc_wblock;
    logic                       mem_we;
    logic [block_width_p-1:0]   mem_wdata;

    // Handshake
    // Ready is gated by reset_i directly, so it reads 0 for the whole reset
    // pulse. It reads 1 in the first cycle after release.
    assign mem_cmd_ready_o = (state_q == S_IDLE) & ~reset_i;
    assign cmd_accept      = mem_cmd_v_i & mem_cmd_ready_o;

    // Address decode
    // The offset subtraction wraps modulo 2^paddr_width_p. Addresses outside
    // the array alias onto it through the index truncation.
    assign rel_addr = mem_cmd_addr_i - mem_offset_p;
    assign cmd_idx  = idx_bits_lp'(rel_addr >> offset_bits_lp);
    assign byte_off = offset_bits_lp'(mem_cmd_addr_i);

    // Uncached sizes above 3 are treated as 8 bytes.
    assign uc_size     = (mem_cmd_size_i > 3'd3) ? 2'd3 : mem_cmd_size_i[1:0];
    // Misaligned uncached accesses are aligned down to their natural size.
    assign off_aligned = (byte_off >> uc_size) << uc_size;
    assign bit_shamt   = {off_aligned, 3'b000};

    assign rd_block = mem_q[cmd_idx];

    // Uncached read: pull the addressed lane down to bit 0, then replicate
    // it across the whole response.
    assign uc_src_word = 64'(rd_block >> bit_shamt);

    always_comb begin
        uc_word = uc_src_word;
        case (uc_size)
            2'd0:    uc_word = {8{uc_src_word[7:0]}};
            2'd1:    uc_word = {4{uc_src_word[15:0]}};
            2'd2:    uc_word = {2{uc_src_word[31:0]}};
            default: uc_word = uc_src_word;
        endcase
    end

    assign uc_rdata = {words_lp{uc_word}};

    // Uncached write: merge the low 2^size bytes of the data into the block.
    always_comb begin
        lane_mask = '1;
        case (uc_size)
            2'd0:    lane_mask = 64'h0000_0000_0000_00ff;
            2'd1:    lane_mask = 64'h0000_0000_0000_ffff;
            2'd2:    lane_mask = 64'h0000_0000_ffff_ffff;
            default: lane_mask = '1;
        endcase
    end

    always_comb begin
        wr_mask_ext       = '0;
        wr_mask_ext[63:0] = lane_mask;
        wr_data_ext       = '0;
        wr_data_ext[63:0] = mem_cmd_data_i[63:0] & lane_mask;
    end

    assign uc_wblock = (rd_block & ~(wr_mask_ext << bit_shamt))
                     | (wr_data_ext << bit_shamt);

    // Both write opcodes have bit 0 set.
    assign mem_we    = cmd_accept & mem_cmd_opcode_i[0];
    assign mem_wdata = (mem_cmd_opcode_i == op_wr_lp) ? mem_cmd_data_i : uc_wblock;

    // The array has no reset, so its contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[cmd_idx] <= mem_wdata;
        end
    end

    // Read data is captured at accept time. With only one command
    // outstanding, nothing can change the block before the response.
    always_comb begin
        resp_data_d = '0;
        case (mem_cmd_opcode_i)
            op_rd_lp:    resp_data_d = rd_block;
            op_uc_rd_lp: resp_data_d = uc_rdata;
            default:     resp_data_d = '0;
        endcase
    end

    // Latency source
`ifdef BP_FE_MEM_RESP_LFSR_LATENCY_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d  = cmd_accept ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lat_total = latency_lp + cnt_width_lp'(lfsr_q[3:0]);
`else
    assign lat_total = latency_lp;
`endif

    // FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    cnt_d   = lat_total;
                    state_d = (lat_total == '0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - cnt_one_lp;
                if (cnt_q == cnt_one_lp) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_resp_yumi_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Response registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_opcode_q  <= '0;
            resp_addr_q    <= '0;
            resp_size_q    <= '0;
            resp_payload_q <= '0;
            resp_data_q    <= '0;
        end else if (cmd_accept) begin
            resp_opcode_q  <= mem_cmd_opcode_i;
            resp_addr_q    <= mem_cmd_addr_i;
            resp_size_q    <= mem_cmd_size_i;
            resp_payload_q <= mem_cmd_payload_i;
            resp_data_q    <= resp_data_d;
        end
    end

    assign mem_resp_v_o       = (state_q == S_RESP);
    assign mem_resp_opcode_o  = resp_opcode_q;
    assign mem_resp_addr_o    = resp_addr_q;
    assign mem_resp_size_o    = resp_size_q;
    assign mem_resp_payload_o = resp_payload_q;
    assign mem_resp_data_o    = resp_data_q;

endmodule
